// File: rtl/ts_packet_mux.sv
// ts_packet_mux: packet-aware N:1 mux forwarding whole TS packets to one FIFO write port.
// Channels switch only on packet boundaries. Misaligned bytes on idle channels are drained
// and flagged, so only complete, SYNC-aligned packets start on the output.
module ts_packet_mux #(
    parameter int unsigned              NUM_CH     = 4,
    parameter int unsigned              DATA_WIDTH = 8,
    parameter int unsigned              PKT_LEN    = 188,
    parameter logic [DATA_WIDTH-1:0]    SYNC_BYTE  = DATA_WIDTH'(8'h47),
    localparam int unsigned             CH_W       = $clog2(NUM_CH),
    localparam int unsigned             CNT_W      = $clog2(PKT_LEN)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    input  logic                         mode,
    input  logic [CH_W-1:0]              sel,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sop,
    output logic                         out_eop,
    output logic [CH_W-1:0]              cur_ch,
    output logic                         pkt_done,
    output logic [NUM_CH-1:0]            sync_err
);

    typedef enum logic {StIdle, StBusy} state_t;

    state_t             r_state, w_state_nxt;
    logic [CH_W-1:0]    r_cur_ch, w_cur_ch_nxt;
    logic [CH_W-1:0]    r_rr_ptr, w_rr_ptr_nxt;
    logic [CNT_W-1:0]   r_byte_cnt, w_byte_cnt_nxt;
    logic               r_pkt_done, w_pkt_done_nxt;
    logic [NUM_CH-1:0]  r_sync_err;

    logic [NUM_CH-1:0]  w_cand;
    logic [NUM_CH-1:0]  w_drain;
    logic               w_gnt_vld;
    logic [CH_W-1:0]    w_gnt;
    logic               w_own_vld;
    logic [CH_W-1:0]    w_own_ch;
    logic               w_last;
    logic               w_xfer;

    assign cur_ch   = r_cur_ch;
    assign pkt_done = r_pkt_done;
    assign sync_err = r_sync_err;

    // Candidate channels: valid byte that looks like a packet start
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            w_cand[k] = in_valid[k] && (in_data[k*DATA_WIDTH +: DATA_WIDTH] == SYNC_BYTE);
        end
    end

    // IDLE arbitration: fixed select or round-robin starting at r_rr_ptr
    always_comb begin
        int unsigned idx;
        idx       = 0;
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        if (!mode) begin
            // Out-of-range select values (non power-of-2 NUM_CH) never grant
            if (32'(sel) < NUM_CH) begin
                w_gnt_vld = w_cand[sel];
                w_gnt     = sel;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                idx = 32'(r_rr_ptr) + i;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
                if (!w_gnt_vld && w_cand[CH_W'(idx)]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = CH_W'(idx);
                end
            end
        end
    end

    // Datapath, output flags, per-channel ready and drain decisions
    always_comb begin
        w_own_vld = (r_state == StBusy) ? 1'b1 : w_gnt_vld;
        w_own_ch  = (r_state == StBusy) ? r_cur_ch : w_gnt;
        w_last    = (r_byte_cnt == CNT_W'(PKT_LEN - 1));
        out_data  = in_data[32'(w_own_ch)*DATA_WIDTH +: DATA_WIDTH];
        if (r_state == StBusy) begin
            out_valid = in_valid[r_cur_ch];
            out_sop   = 1'b0;
            out_eop   = in_valid[r_cur_ch] && w_last;
        end else begin
            out_valid = w_gnt_vld;
            out_sop   = w_gnt_vld;
            out_eop   = 1'b0;
        end
        out_valid = out_valid && rst_n;
        out_sop   = out_sop && rst_n;
        out_eop   = out_eop && rst_n;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_own_vld && (CH_W'(k) == w_own_ch)) begin
                w_drain[k]  = 1'b0;
                in_ready[k] = out_ready && rst_n;
            end else begin
                // Non-owner: misaligned bytes are dropped, SYNC bytes stall
                w_drain[k]  = rst_n && in_valid[k] &&
                              (in_data[k*DATA_WIDTH +: DATA_WIDTH] != SYNC_BYTE);
                in_ready[k] = w_drain[k];
            end
        end
        w_xfer = out_valid && out_ready;
    end

    // Next-state logic for packet FSM, byte counter and round-robin pointer
    always_comb begin
        w_state_nxt    = r_state;
        w_cur_ch_nxt   = r_cur_ch;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_byte_cnt_nxt = r_byte_cnt;
        w_pkt_done_nxt = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_xfer) begin
                    w_state_nxt    = StBusy;
                    w_cur_ch_nxt   = w_gnt;
                    w_byte_cnt_nxt = CNT_W'(1);
                end
            end
            StBusy: begin
                if (w_xfer) begin
                    if (w_last) begin
                        w_state_nxt    = StIdle;
                        w_byte_cnt_nxt = '0;
                        w_pkt_done_nxt = 1'b1;
                        w_rr_ptr_nxt   = (32'(r_cur_ch) == NUM_CH - 1) ? '0
                                                                       : r_cur_ch + 1'b1;
                    end else begin
                        w_byte_cnt_nxt = r_byte_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_cur_ch   <= '0;
            r_rr_ptr   <= '0;
            r_byte_cnt <= '0;
            r_pkt_done <= 1'b0;
            r_sync_err <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_ch   <= w_cur_ch_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_pkt_done <= w_pkt_done_nxt;
            r_sync_err <= w_drain;
        end
    end

endmodule

// File: tb/tb_ts_packet_mux.sv
// Scoreboard bench for ts_packet_mux: per-channel source queues feed the DUT, expected output
// bytes are queued when packets are issued and a negedge monitor pops and compares them.
module tb_ts_packet_mux;

    localparam int NUM_CH  = 4;
    localparam int DW      = 8;
    localparam int PKT_LEN = 188;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_CH*DW-1:0] in_data;
    logic [NUM_CH-1:0]    in_valid;
    logic [NUM_CH-1:0]    in_ready;
    logic                 mode;
    logic [1:0]           sel;
    logic [DW-1:0]        out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_sop;
    logic                 out_eop;
    logic [1:0]           cur_ch;
    logic                 pkt_done;
    logic [NUM_CH-1:0]    sync_err;

    ts_packet_mux dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .cur_ch    (cur_ch),
        .pkt_done  (pkt_done),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        int         ch;
    } exp_t;

    exp_t              exp_q[$];
    exp_t              e;
    logic [7:0]        ch_q[NUM_CH][$];
    logic [7:0]        dummy;
    logic [NUM_CH-1:0] take = '0;
    logic              exp_done = 1'b0;
    int                se_cnt[NUM_CH];
    int                n_out = 0;
    int                total = 0;
    int                bad = 0;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic bit src_busy();
        bit b = 1'b0;
        for (int k = 0; k < NUM_CH; k++) if (ch_q[k].size() != 0) b = 1'b1;
        return b;
    endfunction

    // Queue one packet on channel c; only the first n_exp bytes are expected downstream
    task automatic push_pkt(input int c, input int off, input int n_exp);
        logic [7:0] b;
        for (int i = 0; i < PKT_LEN; i++) begin
            b = (i == 0) ? 8'h47 : 8'(i + off);
            ch_q[c].push_back(b);
            if (i < n_exp) exp_q.push_back('{b, i == 0, i == PKT_LEN - 1, c});
        end
    endtask

    task automatic clr_se();
        for (int k = 0; k < NUM_CH; k++) se_cnt[k] = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int budget, input bit toggle);
        int n = 0;
        while ((exp_q.size() != 0 || src_busy()) && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (toggle) out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        chk("drained_in_budget", int'(n < budget), 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Monitor: handshakes seen here complete on the following posedge
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < NUM_CH; k++) take[k] = in_valid[k] && in_ready[k];
        if (!rst_n) begin
            exp_done = 1'b0;
        end else begin
            if (pkt_done || exp_done) chk("pkt_done", int'(pkt_done), int'(exp_done));
            exp_done = 1'b0;
            for (int k = 0; k < NUM_CH; k++) se_cnt[k] += int'(sync_err[k]);
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", int'(out_data), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte_sop_eop", int'({out_data, out_sop, out_eop}),
                        int'({e.d, e.sop, e.eop}));
                    if (!e.sop) chk("cur_ch", int'(cur_ch), e.ch);
                    exp_done = e.eop;
                end
            end
        end
    end

    // Source driver: retire accepted bytes, then present each channel's next byte
    initial forever begin
        @(posedge clk); #1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (take[k] && ch_q[k].size() != 0) dummy = ch_q[k].pop_front();
            if (ch_q[k].size() != 0) begin
                in_valid[k]          = 1'b1;
                in_data[k*DW +: DW]  = ch_q[k][0];
            end else begin
                in_valid[k]          = 1'b0;
                in_data[k*DW +: DW]  = '0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = 2'd0;
        out_ready = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        clr_se();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cur_ch", int'(cur_ch), 0);
        chk("rst_pkt_done", int'(pkt_done), 0);
        chk("rst_sync_err", int'(sync_err), 0);
        chk("rst_out_valid", int'(out_valid), 0);

        // Fixed select of channel 2, bytes 47,01..BB
        @(posedge clk); #1;
        mode = 1'b0;
        sel  = 2'd2;
        push_pkt(2, 0, PKT_LEN);
        wait_done(400, 1'b0);
        chk("cur_ch_after_pkt", int'(cur_ch), 2);

        // Round-robin over all channels, ch0 holds a second packet
        do_reset();
        clr_se();
        mode = 1'b1;
        push_pkt(0, 20, PKT_LEN);
        push_pkt(1, 40, PKT_LEN);
        push_pkt(2, 60, PKT_LEN);
        push_pkt(3, 80, PKT_LEN);
        push_pkt(0, 100, PKT_LEN);
        wait_done(2000, 1'b0);
        chk("rr_no_sync_err", se_cnt[0] + se_cnt[1] + se_cnt[2] + se_cnt[3], 0);

        // Misaligned bytes on ch1 are drained before its packet
        do_reset();
        clr_se();
        mode = 1'b1;
        ch_q[1].push_back(8'h12);
        ch_q[1].push_back(8'h34);
        push_pkt(1, 7, PKT_LEN);
        wait_done(400, 1'b0);
        chk("sync_err_ch1", se_cnt[1], 2);

        // Downstream back-pressure toggling every cycle
        do_reset();
        mode = 1'b0;
        sel  = 2'd1;
        push_pkt(1, 9, PKT_LEN);
        wait_done(800, 1'b1);

        // Select changes mid-packet only take effect at the boundary
        do_reset();
        mode = 1'b0;
        sel  = 2'd0;
        push_pkt(0, 11, PKT_LEN);
        push_pkt(3, 13, PKT_LEN);
        base = n_out;
        n    = 0;
        while (n_out - base < 10 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        sel = 2'd3;
        wait_done(800, 1'b0);

        // Reset after 100 bytes: partial packet aborted, remainder drained, fresh packet follows
        do_reset();
        clr_se();
        mode = 1'b0;
        sel  = 2'd0;
        push_pkt(0, 0, 100);
        push_pkt(0, 5, PKT_LEN);
        base = n_out;
        n    = 0;
        while (n_out - base != 100 && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("reached_byte_100", n_out - base, 100);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", int'(out_valid), 0);
        chk("rst_mid_out_sop", int'(out_sop), 0);
        chk("rst_mid_out_eop", int'(out_eop), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_cur_ch", int'(cur_ch), 0);
        chk("rst_mid_pkt_done", int'(pkt_done), 0);
        wait_done(800, 1'b0);
        chk("sync_err_ch0_drain", se_cnt[0], PKT_LEN - 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
